// File: rtl/mux41_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of mux41_nand.
// Holds requester count, select width, FSM encoding and the round-robin
// pick helper used for every grant decision.
package mux41_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set bit of req scanning upward from start with modulo-4 wrap.
  // Walking the offsets from highest to lowest lets the nearest hit win.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] start);
    pick_t            r;
    logic [SEL_W-1:0] k;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = start + SEL_W'(i);
      if (req[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux41_nand.sv
// 4:1 multiplexer built purely from NAND terms.
// Ports: s1/s0 select (s1 is MSB), d0..d3 data inputs, y = d[{s1,s0}].
module mux41_nand (
  input  logic s1,
  input  logic s0,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  output logic y
);

  logic n_s1, n_s0;
  logic t0, t1, t2, t3;

  assign n_s1 = ~(s1 & s1);
  assign n_s0 = ~(s0 & s0);

  assign t0 = ~(d0 & n_s1 & n_s0);
  assign t1 = ~(d1 & n_s1 & s0);
  assign t2 = ~(d2 & s1   & n_s0);
  assign t3 = ~(d3 & s1   & s0);

  assign y = ~(t0 & t1 & t2 & t3);

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter sharing one mux41_nand between four requesters.
// A granted owner keeps the mux while it requests, limited to MAX_HOLD
// consecutive cycles when somebody else is waiting.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   req_i[3:0]  request per requester
//   d_i[3:0]    data bit per requester
//   grant_o     registered one-hot grant, zero when idle
//   sel_o       index of current/last owner, drives the mux selects
//   busy_o      grant active
//   y_o         d_i[sel_o] through the NAND mux
//   y_valid_o   same as busy_o
// MAX_HOLD must be 1..7 and 2**CNT_W > MAX_HOLD.
module mux41_rr_arbiter
  import mux41_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] d_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             busy_o,
  output logic             y_o,
  output logic             y_valid_o
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;

  logic [N_REQ-1:0] others;
  pick_t            pick_idle, pick_next;

  // From IDLE the scan resumes after the last owner; inside a grant it
  // resumes after the current owner and never considers the owner itself.
  assign pick_idle = rr_pick(req_i, last_q + SEL_W'(1));
  assign others    = req_i & ~onehot(sel_q);
  assign pick_next = rr_pick(others, sel_q + SEL_W'(1));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_idle.found) begin
          state_d = GRANT;
          sel_d   = pick_idle.idx;
          last_d  = pick_idle.idx;
          cnt_d   = CNT_W'(1);
          grant_d = onehot(pick_idle.idx);
        end
      end
      GRANT: begin
        if (!req_i[sel_q] || (cnt_q >= CNT_W'(MAX_HOLD))) begin
          if (pick_next.found) begin
            // Hand straight over on this edge, no idle bubble.
            sel_d   = pick_next.idx;
            last_d  = pick_next.idx;
            cnt_d   = CNT_W'(1);
            grant_d = onehot(pick_next.idx);
          end else if (!req_i[sel_q]) begin
            // Owner released with nobody waiting; sel stays put so y is stable.
            state_d = IDLE;
            grant_d = '0;
          end
          // Otherwise owner is alone at the cap: keep grant, counter saturates.
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o   = grant_q;
  assign sel_o     = sel_q;
  assign busy_o    = (state_q == GRANT);
  assign y_valid_o = busy_o;

  mux41_nand u_mux (
    .s1(sel_q[1]),
    .s0(sel_q[0]),
    .d0(d_i[0]),
    .d1(d_i[1]),
    .d2(d_i[2]),
    .d3(d_i[3]),
    .y (y_o)
  );

endmodule
